// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline forwarding logic: default widths and the regfile select code.
package pipe_pkg;
  localparam int XLEN_DEF   = 32;
  localparam int REG_AW_DEF = 5;
  localparam int FWD_RF     = 0;
  // tag-entry fields: valid, write-enable, rd, latency
  localparam int TAG_V_W    = 1;
  localparam int TAG_WE_W   = 1;

  function automatic int latWidth(input int maxLat);
    return $clog2(maxLat + 1);
  endfunction
endpackage

// File: rtl/fwd_select.sv
// Per-operand youngest-match priority encoder and data mux over the post-EX tag pipe.
module fwd_select
  import pipe_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int DEPTH  = 2,
  parameter int LAT_W  = 2,
  parameter int SEL_W  = 2
) (
  input  logic [REG_AW-1:0]       rs,
  input  logic [DEPTH-1:0]        tagV,
  input  logic [DEPTH-1:0]        tagWe,
  input  logic [DEPTH*REG_AW-1:0] tagRd,
  input  logic [DEPTH*LAT_W-1:0]  tagLat,
  input  logic [XLEN-1:0]         rfData,
  input  logic [DEPTH*XLEN-1:0]   stageData,
  output logic [XLEN-1:0]         opnd,
  output logic [SEL_W-1:0]        fwdSel,
  output logic                    hazard
);
  logic found;

  // Only the youngest match is considered; an unready one blocks older ready ones.
  always_comb begin
    opnd   = rfData;
    fwdSel = SEL_W'(FWD_RF);
    hazard = 1'b0;
    found  = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      if (!found && tagV[k-1] && tagWe[k-1] && (rs != '0) &&
          (tagRd[(k-1)*REG_AW +: REG_AW] == rs)) begin
        found = 1'b1;
        if (k >= int'(tagLat[(k-1)*LAT_W +: LAT_W])) begin
          opnd   = stageData[(k-1)*XLEN +: XLEN];
          fwdSel = SEL_W'(k);
        end else begin
          hazard = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/operand_forward_unit.sv
// EX-stage operand forwarding and hazard unit: tag shift pipe, per-operand selectors, stall and counters.
module operand_forward_unit
  import pipe_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int REG_AW  = REG_AW_DEF,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 2,
  parameter int MAX_LAT = 2,
  parameter int CNT_W   = 16,
  localparam int LAT_W  = $clog2(MAX_LAT + 1),
  localparam int SEL_W  = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ex_valid,
  input  logic                      ex_flush,
  input  logic                      ex_we,
  input  logic [REG_AW-1:0]         ex_rd,
  input  logic [LAT_W-1:0]          ex_lat,
  input  logic [NUM_SRC*REG_AW-1:0] ex_rs,
  input  logic [NUM_SRC*XLEN-1:0]   rf_data,
  input  logic [DEPTH*XLEN-1:0]     stage_data,
  output logic [NUM_SRC*XLEN-1:0]   opnd,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic                      stall,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [CNT_W-1:0]          fwd_cnt
);
  logic [DEPTH-1:0]        tagV;
  logic [DEPTH-1:0]        tagWe;
  logic [DEPTH*REG_AW-1:0] tagRd;
  logic [DEPTH*LAT_W-1:0]  tagLat;
  logic [NUM_SRC-1:0]      hazard;
  logic                    anyFwd;

  for (genvar i = 0; i < NUM_SRC; i++) begin : gSrc
    fwd_select #(
      .XLEN(XLEN), .REG_AW(REG_AW), .DEPTH(DEPTH), .LAT_W(LAT_W), .SEL_W(SEL_W)
    ) uSel (
      .rs       (ex_rs[i*REG_AW +: REG_AW]),
      .tagV     (tagV),
      .tagWe    (tagWe),
      .tagRd    (tagRd),
      .tagLat   (tagLat),
      .rfData   (rf_data[i*XLEN +: XLEN]),
      .stageData(stage_data),
      .opnd     (opnd[i*XLEN +: XLEN]),
      .fwdSel   (fwd_sel[i*SEL_W +: SEL_W]),
      .hazard   (hazard[i])
    );
  end

  assign stall  = ex_valid & ~ex_flush & (|hazard);
  assign anyFwd = ex_valid & ~stall & (|fwd_sel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tagV      <= '0;
      tagWe     <= '0;
      tagRd     <= '0;
      tagLat    <= '0;
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      // A stalled or flushed EX instruction leaves a bubble behind in stage 1.
      tagV[0]              <= ex_valid & ~ex_flush & ~stall;
      tagWe[0]             <= ex_we;
      tagRd[0 +: REG_AW]   <= ex_rd;
      tagLat[0 +: LAT_W]   <= ex_lat;
      for (int k = 1; k < DEPTH; k++) begin
        tagV[k]                   <= tagV[k-1];
        tagWe[k]                  <= tagWe[k-1];
        tagRd[k*REG_AW +: REG_AW] <= tagRd[(k-1)*REG_AW +: REG_AW];
        tagLat[k*LAT_W +: LAT_W]  <= tagLat[(k-1)*LAT_W +: LAT_W];
      end
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (anyFwd && (fwd_cnt != '1)) fwd_cnt <= fwd_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_operand_forward_unit.sv
// Table-driven bench for operand_forward_unit with a queue scoreboard and hand-written reset/saturation sequences.
module tb_operand_forward_unit;
  localparam int XLEN = 32, REG_AW = 5, NUM_SRC = 2, DEPTH = 2, MAX_LAT = 2, CNT_W = 4;
  localparam int SAT = (1 << CNT_W) - 1;
  localparam logic [31:0] RF0 = 32'h0F00_0000, RF1 = 32'h0F11_0000;

  logic clk = 1'b0, rst_n = 1'b0;
  logic exValid = 1'b0, exFlush = 1'b0, exWe = 1'b0;
  logic [4:0] exRd = '0;
  logic [1:0] exLat = 2'd1;
  logic [9:0] exRs = '0;
  logic [63:0] rfData, stageData = '0;
  logic [63:0] opnd;
  logic [3:0] fwdSel;
  logic stall;
  logic [CNT_W-1:0] stallCnt, fwdCnt;

  assign rfData = {RF1, RF0};
  always #5 clk = ~clk;

  operand_forward_unit #(
    .XLEN(XLEN), .REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .MAX_LAT(MAX_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(exValid), .ex_flush(exFlush), .ex_we(exWe),
    .ex_rd(exRd), .ex_lat(exLat), .ex_rs(exRs), .rf_data(rfData), .stage_data(stageData),
    .opnd(opnd), .fwd_sel(fwdSel), .stall(stall), .stall_cnt(stallCnt), .fwd_cnt(fwdCnt)
  );

  typedef struct {
    int v, fl, we, rd, lat, rs0, rs1;
    logic [31:0] s1, s2;
    int chk, sel0, sel1, stall;
  } vec_t;

  typedef struct {
    int idx, chk, sel0, sel1, stall, sc, fc;
    logic [31:0] op0, op1;
  } exp_t;

  vec_t vt[21];
  exp_t sb[$];
  int total = 0, bad = 0;
  int mStall = 0, mFwd = 0;

  function automatic vec_t mk(int v, int fl, int we, int rd, int lat, int rs0, int rs1,
                              logic [31:0] s1, logic [31:0] s2, int chk, int sel0, int sel1, int st);
    vec_t t;
    t.v = v; t.fl = fl; t.we = we; t.rd = rd; t.lat = lat; t.rs0 = rs0; t.rs1 = rs1;
    t.s1 = s1; t.s2 = s2; t.chk = chk; t.sel0 = sel0; t.sel1 = sel1; t.stall = st;
    return t;
  endfunction

  function automatic logic [31:0] pick(int sel, logic [31:0] rf, logic [31:0] s1, logic [31:0] s2);
    return (sel == 1) ? s1 : (sel == 2) ? s2 : rf;
  endfunction

  task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d got=%h want=%h", name, idx, act, exp);
    end
  endtask

  task automatic applyVec(vec_t t, int idx);
    exp_t e, g;
    @(posedge clk);
    #1;
    exValid = 1'(t.v); exFlush = 1'(t.fl); exWe = 1'(t.we);
    exRd = 5'(t.rd); exLat = 2'(t.lat);
    exRs = {5'(t.rs1), 5'(t.rs0)};
    stageData = {t.s2, t.s1};
    e.idx = idx; e.chk = t.chk; e.sel0 = t.sel0; e.sel1 = t.sel1; e.stall = t.stall;
    e.sc = mStall; e.fc = mFwd;
    e.op0 = pick(t.sel0, RF0, t.s1, t.s2);
    e.op1 = pick(t.sel1, RF1, t.s1, t.s2);
    sb.push_back(e);
    if (t.stall != 0 && mStall < SAT) mStall++;
    if (t.v != 0 && t.stall == 0 && (t.sel0 != 0 || t.sel1 != 0) && mFwd < SAT) mFwd++;
    @(negedge clk);
    g = sb.pop_front();
    check("stall", g.idx, {31'b0, stall}, 32'(g.stall));
    check("stall_cnt", g.idx, 32'(stallCnt), 32'(g.sc));
    check("fwd_cnt", g.idx, 32'(fwdCnt), 32'(g.fc));
    if (g.chk != 0) begin
      check("fwd_sel0", g.idx, 32'(fwdSel[1:0]), 32'(g.sel0));
      check("fwd_sel1", g.idx, 32'(fwdSel[3:2]), 32'(g.sel1));
      check("opnd0", g.idx, opnd[31:0], g.op0);
      check("opnd1", g.idx, opnd[63:32], g.op1);
    end
  endtask

  initial begin
    //          v fl we rd lat rs0 rs1 s1            s2            chk sel0 sel1 stall
    vt[0]  = mk(1, 0, 1, 5, 1, 0, 0, 32'h0,        32'h0,        1, 0, 0, 0); // add x5
    vt[1]  = mk(1, 0, 0, 0, 1, 5, 0, 32'h1234,     32'h5555,     1, 1, 0, 0); // ALU->ALU
    vt[2]  = mk(1, 0, 1, 7, 2, 0, 0, 32'h0,        32'h0,        1, 0, 0, 0); // lw x7
    vt[3]  = mk(1, 0, 0, 0, 1, 0, 7, 32'h0,        32'h0,        0, 0, 0, 1); // load-use stall
    vt[4]  = mk(1, 0, 0, 0, 1, 0, 7, 32'h1111,     32'h7777,     1, 0, 2, 0);
    vt[5]  = mk(1, 0, 1, 3, 1, 0, 0, 32'h0,        32'h0,        1, 0, 0, 0);
    vt[6]  = mk(1, 0, 1, 3, 1, 0, 0, 32'h0,        32'h0,        1, 0, 0, 0);
    vt[7]  = mk(1, 0, 0, 0, 1, 3, 3, 32'hBBBB,     32'hAAAA,     1, 1, 1, 0); // youngest wins
    vt[8]  = mk(1, 0, 1, 3, 1, 0, 0, 32'h0,        32'h0,        1, 0, 0, 0);
    vt[9]  = mk(1, 0, 1, 3, 2, 0, 0, 32'h0,        32'h0,        1, 0, 0, 0);
    vt[10] = mk(1, 0, 0, 0, 1, 3, 0, 32'hBBBB,     32'hAAAA,     0, 0, 0, 1); // unready youngest
    vt[11] = mk(1, 0, 0, 0, 1, 3, 0, 32'hBBBB,     32'hCCCC,     1, 2, 0, 0);
    vt[12] = mk(1, 0, 1, 0, 1, 0, 0, 32'h0,        32'h0,        1, 0, 0, 0); // write x0
    vt[13] = mk(1, 0, 0, 9, 1, 0, 0, 32'h1,        32'h2,        1, 0, 0, 0);
    vt[14] = mk(1, 0, 0, 0, 1, 9, 9, 32'h3,        32'h4,        1, 0, 0, 0); // we=0 match
    vt[15] = mk(1, 0, 1, 7, 2, 0, 0, 32'h0,        32'h0,        1, 0, 0, 0);
    vt[16] = mk(1, 1, 0, 0, 1, 0, 7, 32'h0,        32'h0,        0, 0, 0, 0); // flush beats stall
    vt[17] = mk(1, 0, 0, 0, 1, 0, 7, 32'h8888,     32'hDEAD,     1, 0, 2, 0); // load retired
    vt[18] = mk(1, 0, 1, 4, 2, 0, 0, 32'h0,        32'h0,        1, 0, 0, 0);
    vt[19] = mk(0, 0, 0, 0, 1, 4, 0, 32'h0,        32'h0,        0, 0, 0, 0); // invalid EX
    vt[20] = mk(1, 0, 0, 0, 1, 4, 0, 32'h9999,     32'hBEEF,     1, 2, 0, 0);

    #2;
    check("rst_stall", -1, {31'b0, stall}, 32'd0);
    check("rst_sel", -1, 32'(fwdSel), 32'd0);
    check("rst_opnd0", -1, opnd[31:0], RF0);
    check("rst_stall_cnt", -1, 32'(stallCnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) applyVec(vt[i], i);

    // Repeated load-use pairs drive both counters into saturation.
    for (int n = 0; n < 16; n++) begin
      applyVec(mk(1, 0, 1, 7, 2, 0, 0, 32'h0, 32'h0, 1, 0, 0, 0), 100 + 3*n);
      applyVec(mk(1, 0, 0, 0, 1, 0, 7, 32'h0, 32'h0, 0, 0, 0, 1), 101 + 3*n);
      applyVec(mk(1, 0, 0, 0, 1, 0, 7, 32'h0, 32'h4242, 1, 0, 2, 0), 102 + 3*n);
    end
    check("sat_stall_cnt", 200, 32'(stallCnt), 32'(SAT));
    check("sat_fwd_cnt", 200, 32'(fwdCnt), 32'(SAT));

    // Asynchronous reset in the middle of a load-use stall.
    applyVec(mk(1, 0, 1, 7, 2, 0, 0, 32'h0, 32'h0, 1, 0, 0, 0), 300);
    @(posedge clk);
    #1;
    exValid = 1'b1; exFlush = 1'b0; exWe = 1'b0; exRs = {5'd7, 5'd0};
    #1;
    check("pre_rst_stall", 301, {31'b0, stall}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_stall", 301, {31'b0, stall}, 32'd0);
    check("mid_rst_sel", 301, 32'(fwdSel), 32'd0);
    check("mid_rst_opnd1", 301, opnd[63:32], RF1);
    check("mid_rst_stall_cnt", 301, 32'(stallCnt), 32'd0);
    check("mid_rst_fwd_cnt", 301, 32'(fwdCnt), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mStall = 0;
    mFwd = 0;
    applyVec(mk(1, 0, 0, 0, 1, 0, 7, 32'h0, 32'h0, 1, 0, 0, 0), 302);

    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_left got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
